lpif_tx_framer: RTL and testbench

LPIF_TX_FRAMER -- requirements
Module: lpif_tx_framer

---
 rtl/lpif_pkg.sv | 30 +++
 rtl/sym_queue.sv | 64 ++++++
 rtl/lpif_tx_framer.sv | 170 +++++++++++++++++
 tb/tb_lpif_tx_framer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_pkg.sv
// Shared framing constants, FSM state type and queue symbol type for the LPIF TX framer.
package lpif_pkg;

   localparam logic [7:0] STP = 8'hFB;
   localparam logic [7:0] SDP = 8'h5C;
   localparam logic [7:0] END = 8'hFD;
   localparam logic [7:0] EDB = 8'hFE;
   localparam logic [7:0] PAD = 8'h00;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IN_TLP  = 2'd1,
      IN_DLLP = 2'd2
   } lpif_state_e;

   typedef struct packed {
      logic [7:0] data;
      logic       k;
   } sym_t;

   localparam int SYM_W = $bits(sym_t);

   function automatic sym_t mk_sym(input logic [7:0] data, input logic k);
      sym_t s;
      s.data = data;
      s.k    = k;
      return s;
   endfunction

endpackage

// File: rtl/sym_queue.sv
// Circular symbol buffer: up to WR_MAX pushes and RD_MAX pops per cycle, head window
// visible combinationally. Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module sym_queue
   import lpif_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int WR_MAX = 8,
   parameter int RD_MAX = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic [$clog2(WR_MAX+1)-1:0]     wr_cnt,
   input  sym_t [WR_MAX-1:0]               wr_sym,
   input  logic [$clog2(RD_MAX+1)-1:0]     rd_cnt,
   output sym_t [RD_MAX-1:0]               rd_sym,
   output logic [$clog2(DEPTH+1)-1:0]      count,
   output logic [$clog2(DEPTH+1)-1:0]      free
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   sym_t          mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= wrap_add(rd_ptr, int'(rd_cnt));
         wr_ptr <= wrap_add(wr_ptr, int'(wr_cnt));
         count  <= CW'(int'(count) + int'(wr_cnt) - int'(rd_cnt));
      end
   end

   // Storage carries no reset; only entries between the pointers are ever observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WR_MAX; i++) begin
         if (!flush && i < int'(wr_cnt)) mem[wrap_add(wr_ptr, i)] <= wr_sym[i];
      end
   end

   always_comb begin
      for (int i = 0; i < RD_MAX; i++) rd_sym[i] = mem[wrap_add(rd_ptr, i)];
   end

   assign free = CW'(DEPTH) - count;

endmodule

// File: rtl/lpif_tx_framer.sv
// LPIF transmit framer: expands link-layer byte lanes into STP/SDP/END/EDB-framed
// symbols, checks the tag sequence and streams NB symbols per cycle toward PIPE.
module lpif_tx_framer
   import lpif_pkg::*;
#(
   parameter int LPIF_BUS_WIDTH = 32,
   parameter int QUEUE_DEPTH    = 4 * (LPIF_BUS_WIDTH / 8)
) (
   input  logic                          lclk,
   input  logic                          reset_n,
   input  logic                          link_active,
   input  logic                          lp_irdy,
   input  logic [LPIF_BUS_WIDTH-1:0]     lp_data,
   input  logic [LPIF_BUS_WIDTH/8-1:0]   lp_valid,
   input  logic [LPIF_BUS_WIDTH/8-1:0]   lp_tlp_start,
   input  logic [LPIF_BUS_WIDTH/8-1:0]   lp_tlp_end,
   input  logic [LPIF_BUS_WIDTH/8-1:0]   lp_dllp_start,
   input  logic [LPIF_BUS_WIDTH/8-1:0]   lp_dllp_end,
   input  logic [LPIF_BUS_WIDTH/8-1:0]   lp_tlpedb,
   output logic                          pl_trdy,
   output logic [LPIF_BUS_WIDTH-1:0]     tx_data,
   output logic [LPIF_BUS_WIDTH/8-1:0]   tx_datak,
   output logic                          tx_data_valid,
   output logic                          framing_err,
   output lpif_state_e                   dbg_state
);

   localparam int NB      = LPIF_BUS_WIDTH / 8;
   localparam int WR_MAX  = 2 * NB;
   localparam int EXP_MAX = 3 * NB;
   localparam int CW      = $clog2(QUEUE_DEPTH + 1);
   localparam int WCW     = $clog2(WR_MAX + 1);
   localparam int RCW     = $clog2(NB + 1);

   lpif_state_e               state;
   lpif_state_e               st_walk;
   lpif_state_e               fsm_next;
   logic                      run_q;
   logic                      valid_q;
   logic                      accept;
   logic                      err_walk;
   logic                      trunc_err;
   int                        exp_n;
   logic [EXP_MAX*SYM_W-1:0]  exp_vec;
   logic [EXP_MAX*SYM_W-1:0]  aligned;
   sym_t [WR_MAX-1:0]         wr_sym;
   logic [WCW-1:0]            wr_cnt;
   logic [RCW-1:0]            rd_cnt;
   sym_t [NB-1:0]             rd_sym;
   logic [CW-1:0]             q_count;
   logic [CW-1:0]             q_free;
   logic [LPIF_BUS_WIDTH-1:0] nxt_data;
   logic [NB-1:0]             nxt_k;
   logic                      nxt_valid;

   // A word transfers on a rising edge where lp_irdy && pl_trdy; pl_trdy never depends on
   // lp_irdy, and reserving 2*NB free entries guarantees the whole word fits in one push.
   assign pl_trdy = run_q & link_active & (int'(q_free) >= WR_MAX);
   assign accept  = lp_irdy & pl_trdy;

   // Walk the lanes in order; symbols shift in from the top and are realigned afterwards.
   always_comb begin
      exp_vec  = '0;
      exp_n    = 0;
      st_walk  = state;
      err_walk = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (lp_valid[i]) begin
            if (lp_tlp_start[i] || lp_dllp_start[i]) begin
               if (st_walk != IDLE || (lp_tlp_start[i] && lp_dllp_start[i])) err_walk = 1'b1;
               exp_vec = {mk_sym(lp_tlp_start[i] ? STP : SDP, 1'b1), exp_vec[EXP_MAX*SYM_W-1:SYM_W]};
               exp_n   = exp_n + 1;
               st_walk = lp_tlp_start[i] ? IN_TLP : IN_DLLP;
            end
            exp_vec = {mk_sym(lp_data[8*i +: 8], 1'b0), exp_vec[EXP_MAX*SYM_W-1:SYM_W]};
            exp_n   = exp_n + 1;
            if (lp_tlp_end[i] || lp_dllp_end[i]) begin
               if ((lp_tlp_end[i] && st_walk != IN_TLP) ||
                   (lp_dllp_end[i] && st_walk != IN_DLLP) ||
                   (lp_dllp_end[i] && lp_tlpedb[i])) err_walk = 1'b1;
               exp_vec = {mk_sym(lp_tlpedb[i] ? EDB : END, 1'b1), exp_vec[EXP_MAX*SYM_W-1:SYM_W]};
               exp_n   = exp_n + 1;
               st_walk = IDLE;
            end
         end
      end
   end

   // A word of single-byte packets can exceed the 2*NB push window; the excess is cut and flagged.
   assign aligned   = exp_vec >> (SYM_W * (EXP_MAX - exp_n));
   assign wr_sym    = aligned[WR_MAX*SYM_W-1:0];
   assign wr_cnt    = accept ? WCW'((exp_n > WR_MAX) ? WR_MAX : exp_n) : '0;
   assign trunc_err = accept && (exp_n > WR_MAX);
   assign fsm_next  = accept ? st_walk : state;

   // Pop decisions use the pre-write count, so a symbol pushed at edge N leaves at N+1 at the earliest.
   always_comb begin
      rd_cnt    = '0;
      nxt_data  = '0;
      nxt_k     = '0;
      nxt_valid = 1'b1;
      if (int'(q_count) >= NB) begin
         rd_cnt = RCW'(NB);
         for (int i = 0; i < NB; i++) begin
            nxt_data[8*i +: 8] = rd_sym[i].data;
            nxt_k[i]           = rd_sym[i].k;
         end
      end else if (q_count != '0) begin
         if (fsm_next == IDLE) begin
            rd_cnt = RCW'(q_count);
            for (int i = 0; i < NB; i++) begin
               if (i < int'(q_count)) begin
                  nxt_data[8*i +: 8] = rd_sym[i].data;
                  nxt_k[i]           = rd_sym[i].k;
               end else begin
                  nxt_data[8*i +: 8] = PAD;
               end
            end
         end else begin
            nxt_valid = 1'b0;
         end
      end
   end

   always_ff @(posedge lclk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         run_q       <= 1'b0;
         tx_data     <= '0;
         tx_datak    <= '0;
         valid_q     <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (!link_active) begin
            state       <= IDLE;
            tx_data     <= '0;
            tx_datak    <= '0;
            valid_q     <= 1'b0;
            framing_err <= 1'b0;
         end else begin
            state       <= fsm_next;
            tx_data     <= nxt_data;
            tx_datak    <= nxt_k;
            valid_q     <= nxt_valid;
            framing_err <= accept && (err_walk || trunc_err);
         end
      end
   end

   assign tx_data_valid = valid_q & link_active;
   assign dbg_state     = state;

   sym_queue #(
      .DEPTH  (QUEUE_DEPTH),
      .WR_MAX (WR_MAX),
      .RD_MAX (NB)
   ) u_sym_queue (
      .clk    (lclk),
      .rst_n  (reset_n),
      .flush  (!link_active),
      .wr_cnt (wr_cnt),
      .wr_sym (wr_sym),
      .rd_cnt (rd_cnt),
      .rd_sym (rd_sym),
      .count  (q_count),
      .free   (q_free)
   );

endmodule

// File: tb/tb_lpif_tx_framer.sv
// Self-checking bench for lpif_tx_framer: directed framing cases plus a back-to-back
// packet stream checked symbol by symbol against an expected queue.
module tb_lpif_tx_framer;
   import lpif_pkg::*;

   localparam int W     = 32;
   localparam int NB    = 4;
   localparam int DEPTH = 16;

   logic        lclk;
   logic        reset_n;
   logic        link_active;
   logic        lp_irdy;
   logic [W-1:0]  lp_data;
   logic [NB-1:0] lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, lp_tlpedb;
   logic          pl_trdy;
   logic [W-1:0]  tx_data;
   logic [NB-1:0] tx_datak;
   logic          tx_data_valid;
   logic          framing_err;
   lpif_state_e   dbg_state;

   int          n_vec = 0;
   int          n_err = 0;
   logic [8:0]  exp_q[$];
   int          push_pend = 0;
   int          occ = 0;
   bit          check_trdy = 0;
   bit          saw_trdy_low = 0;

   lpif_tx_framer #(.LPIF_BUS_WIDTH(W), .QUEUE_DEPTH(DEPTH)) dut (
      .lclk          (lclk),
      .reset_n       (reset_n),
      .link_active   (link_active),
      .lp_irdy       (lp_irdy),
      .lp_data       (lp_data),
      .lp_valid      (lp_valid),
      .lp_tlp_start  (lp_tlp_start),
      .lp_tlp_end    (lp_tlp_end),
      .lp_dllp_start (lp_dllp_start),
      .lp_dllp_end   (lp_dllp_end),
      .lp_tlpedb     (lp_tlpedb),
      .pl_trdy       (pl_trdy),
      .tx_data       (tx_data),
      .tx_datak      (tx_datak),
      .tx_data_valid (tx_data_valid),
      .framing_err   (framing_err),
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial lclk = 1'b0;
   always #5 lclk = ~lclk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected symbol stream of one accepted word, straight from the framing rules.
   task automatic model_push(input logic [W-1:0] d, input logic [NB-1:0] v, ts, te, ds, de, edb,
                             output int n);
      n = 0;
      for (int i = 0; i < NB; i++) begin
         if (v[i]) begin
            if (ts[i])      begin exp_q.push_back({1'b1, 8'hFB}); n++; end
            else if (ds[i]) begin exp_q.push_back({1'b1, 8'h5C}); n++; end
            exp_q.push_back({1'b0, d[8*i +: 8]}); n++;
            if (te[i] || de[i]) begin
               exp_q.push_back({1'b1, edb[i] ? 8'hFE : 8'hFD}); n++;
            end
         end
      end
   endtask

   // driver: call at a falling edge; returns at the falling edge after acceptance
   task automatic send_word(input logic [W-1:0] d, input logic [NB-1:0] v, ts, te, ds, de, edb,
                            input logic exp_err);
      int t;
      int n;
      t = 0;
      lp_data = d; lp_valid = v; lp_tlp_start = ts; lp_tlp_end = te;
      lp_dllp_start = ds; lp_dllp_end = de; lp_tlpedb = edb; lp_irdy = 1'b1;
      while (!pl_trdy && t < 200) begin
         @(negedge lclk);
         t++;
      end
      if (!pl_trdy) begin
         check("trdy_timeout", {31'd0, pl_trdy}, 32'd1);
         lp_irdy = 1'b0;
         return;
      end
      @(posedge lclk);
      model_push(d, v, ts, te, ds, de, edb, n);
      push_pend += n;
      @(negedge lclk);
      check("framing_err", {31'd0, framing_err}, {31'd0, exp_err});
   endtask

   task automatic idle_bus();
      lp_irdy = 1'b0; lp_valid = '0; lp_tlp_start = '0; lp_tlp_end = '0;
      lp_dllp_start = '0; lp_dllp_end = '0; lp_tlpedb = '0;
   endtask

   // scoreboard: pop expected symbols as real (non-filler) symbols leave the DUT
   initial begin : monitor
      int         popped;
      logic [8:0] sym;
      forever begin
         @(negedge lclk);
         if (!reset_n || !link_active) begin
            exp_q.delete();
            push_pend = 0;
            occ = 0;
         end else begin
            popped = 0;
            if (tx_data_valid) begin
               for (int i = 0; i < NB; i++) begin
                  sym = {tx_datak[i], tx_data[8*i +: 8]};
                  if (sym != 9'h000) begin
                     popped++;
                     if (exp_q.size() == 0) check("sb_unexpected", {23'd0, sym}, 32'd0);
                     else check("sb_sym", {23'd0, sym}, {23'd0, exp_q.pop_front()});
                  end
               end
            end
            occ = occ + push_pend - popped;
            push_pend = 0;
            if (check_trdy) begin
               check("trdy_vs_free", {31'd0, pl_trdy}, {31'd0, (DEPTH - occ) >= 2 * NB});
               if (!pl_trdy) saw_trdy_low = 1;
            end
         end
      end
   end

   initial begin : stim
      logic [W-1:0] d;
      logic         tlp;
      int           t;
      reset_n = 1'b0; link_active = 1'b1;
      lp_data = '0;
      idle_bus();
      #3;
      check("rst_tx_data",  tx_data, 32'd0);
      check("rst_tx_datak", {28'd0, tx_datak}, 32'd0);
      check("rst_valid",    {31'd0, tx_data_valid}, 32'd0);
      check("rst_ferr",     {31'd0, framing_err}, 32'd0);
      check("rst_trdy",     {31'd0, pl_trdy}, 32'd0);
      check("rst_state",    {30'd0, dbg_state}, {30'd0, IDLE});
      @(negedge lclk); @(negedge lclk);
      reset_n = 1'b1;
      @(negedge lclk);
      check("idle_valid", {31'd0, tx_data_valid}, 32'd1);
      check("idle_data",  tx_data, 32'd0);
      check("idle_trdy",  {31'd0, pl_trdy}, 32'd1);

      // TLP FB,11,22,33,44,FD
      send_word(32'h44332211, 4'hF, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      idle_bus();
      check("tlp_w0_idle", tx_data, 32'd0);
      @(negedge lclk);
      check("tlp_w1_data", tx_data, 32'h332211FB);
      check("tlp_w1_k",    {28'd0, tx_datak}, 32'h1);
      @(negedge lclk);
      check("tlp_w2_data", tx_data, 32'h0000FD44);
      check("tlp_w2_k",    {28'd0, tx_datak}, 32'h2);
      check("tlp_w2_valid", {31'd0, tx_data_valid}, 32'd1);

      // DLLP 5C,AA,BB,CC,DD,FD
      send_word(32'hDDCCBBAA, 4'hF, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 1'b0);
      idle_bus();
      @(negedge lclk);
      check("dllp_w1_data", tx_data, 32'hCCBBAA5C);
      check("dllp_w1_k",    {28'd0, tx_datak}, 32'h1);
      @(negedge lclk);
      check("dllp_w2_data", tx_data, 32'h0000FDDD);

      // TLP ending in EDB, then DLLP illegally ending in EDB
      send_word(32'h44332211, 4'hF, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0);
      idle_bus();
      @(negedge lclk); @(negedge lclk);
      check("edb_w2_data", tx_data, 32'h0000FE44);
      check("edb_w2_k",    {28'd0, tx_datak}, 32'h2);
      send_word(32'h88776655, 4'hF, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b1000, 1'b1);
      idle_bus();
      check("dllp_edb_state", {30'd0, dbg_state}, {30'd0, IDLE});
      @(negedge lclk);
      check("ferr_one_cycle", {31'd0, framing_err}, 32'd0);

      // tlp_end while IDLE
      send_word(32'h04030201, 4'hF, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1);
      idle_bus();
      check("end_idle_state", {30'd0, dbg_state}, {30'd0, IDLE});

      // invalid lanes drop their tags (the dllp_start on lane 1 must vanish)
      send_word(32'h44332211, 4'b0101, 4'b0001, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 1'b0);
      idle_bus();
      // both start tags on one lane
      send_word(32'h5A5B5C5D, 4'hF, 4'b0001, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      idle_bus();
      repeat (3) @(negedge lclk);

      // open TLP stalls its tail, then a DLLP start inside it is a violation
      send_word(32'h0D0C0B0A, 4'hF, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      idle_bus();
      @(negedge lclk);
      check("stall_w1_data", tx_data, 32'h0C0B0AFB);
      @(negedge lclk);
      check("stall_valid", {31'd0, tx_data_valid}, 32'd0);
      check("stall_state", {30'd0, dbg_state}, {30'd0, IN_TLP});
      send_word(32'h1D1C1B1A, 4'hF, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 1'b1);
      idle_bus();
      repeat (4) @(negedge lclk);

      // link drop mid-TLP
      send_word(32'h2D2C2B2A, 4'hF, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      idle_bus();
      repeat (2) @(negedge lclk);
      link_active = 1'b0;
      #1;
      check("link_low_valid", {31'd0, tx_data_valid}, 32'd0);
      check("link_low_trdy",  {31'd0, pl_trdy}, 32'd0);
      @(negedge lclk);
      check("link_low_state", {30'd0, dbg_state}, {30'd0, IDLE});
      @(negedge lclk);
      link_active = 1'b1;
      @(negedge lclk);
      check("link_up_valid", {31'd0, tx_data_valid}, 32'd1);
      check("link_up_data",  tx_data, 32'd0);
      check("link_up_state", {30'd0, dbg_state}, {30'd0, IDLE});
      send_word(32'h3D3C3B3A, 4'hF, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      idle_bus();
      repeat (3) @(negedge lclk);

      // reset mid-TLP: outputs clear immediately, no memory afterwards
      send_word(32'h4D4C4B4A, 4'hF, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      idle_bus();
      @(negedge lclk);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_data",  tx_data, 32'd0);
      check("mid_rst_k",     {28'd0, tx_datak}, 32'd0);
      check("mid_rst_valid", {31'd0, tx_data_valid}, 32'd0);
      check("mid_rst_trdy",  {31'd0, pl_trdy}, 32'd0);
      check("mid_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
      @(negedge lclk); @(negedge lclk);
      reset_n = 1'b1;
      @(negedge lclk); @(negedge lclk);
      send_word(32'h5D5C5B5A, 4'hF, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      idle_bus();
      repeat (4) @(negedge lclk);

      // back-to-back 4-byte packets with irdy held high
      check_trdy = 1;
      for (int k = 0; k < 40; k++) begin
         for (int b = 0; b < NB; b++) d[8*b +: 8] = 8'($urandom_range(1, 255));
         tlp = 1'($urandom_range(0, 1));
         if (tlp)
            send_word(d, 4'hF, 4'b0001, 4'b1000, 4'b0000, 4'b0000,
                      ($urandom_range(0, 3) == 0) ? 4'b1000 : 4'b0000, 1'b0);
         else
            send_word(d, 4'hF, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 1'b0);
      end
      idle_bus();
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge lclk);
         t++;
      end
      @(negedge lclk);
      check_trdy = 0;
      check("sb_drained", exp_q.size(), 32'd0);
      check("backpressure_seen", {31'd0, saw_trdy_low}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
